muldiv_sequencer: RTL and testbench

- Multi-cycle sequencer for the integer multiply/divide resource used by the CPU54 core for MUL, MULTU, DIV and DIVU.
- Accepts one operation from the decode/controller stage and stalls the PC/regfile path while it runs.
- Iterates a radix-2 shift-add multiplier or a restoring divider over 32 cycles.
- On completion it presents the HI/LO result, or the MUL rd result, with write strobes.

---
 rtl/muldiv_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle sequencer for MUL, MULTU, DIV and DIVU.
// It runs a radix-2 shift-add multiplier or a restoring divider for WIDTH cycles on operand
// magnitudes, then applies the sign fix-up and presents the HI/LO results with write strobes.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start, op, a, b operation request; sampled only in IDLE
//                   op: 00 MUL, 01 MULTU, 10 DIV, 11 DIVU
//   flush           synchronous abort; returns to IDLE and suppresses all strobes
//   stall           holds the PC/regfile path while an operation is in flight
//   busy            state is not IDLE
//   done            one-cycle completion pulse
//   hi_out, lo_out  HI (remainder / high product) and LO (quotient / low product)
//   hi_w, lo_w      HI/LO write strobes
//   rd_w            MUL rd write strobe; rd data is lo_out
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             hi_w,
    output logic             lo_w,
    output logic             rd_w
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    localparam logic [1:0] OpMul   = 2'b00;
    localparam logic [1:0] OpMultu = 2'b01;
    localparam logic [1:0] OpDiv   = 2'b10;
    localparam logic [1:0] OpDivu  = 2'b11;

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    // opb: multiplicand for multiplies, divisor for divides (magnitude for signed ops)
    logic [WIDTH-1:0]   opb_q, opb_d;
    // high: product accumulator / partial remainder
    logic [WIDTH-1:0]   high_q, high_d;
    // low: multiplier (shifted out as product bits enter) / dividend-quotient register
    logic [WIDTH-1:0]   low_q, low_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_out_q, hi_out_d;
    logic [WIDTH-1:0]   lo_out_q, lo_out_d;
    logic               done_q, done_d;
    logic               hi_w_q, hi_w_d;
    logic               lo_w_q, lo_w_d;
    logic               rd_w_q, rd_w_d;

    // Datapath helpers
    logic               in_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_diff;
    logic               rem_ge;
    logic [2*WIDTH-1:0] prod;
    logic               div_zero;
    logic [WIDTH-1:0]   rem_signed;

    assign in_signed = ~op[0];
    assign a_neg     = in_signed & a[WIDTH-1];
    assign b_neg     = in_signed & b[WIDTH-1];

    // Shift-add step; the extra top bit is the carry shifted back into the accumulator.
    assign mul_sum = {1'b0, high_q} + (low_q[0] ? {1'b0, opb_q} : '0);

    // Restoring step: shift {rem, quot} left and trial-subtract the divisor.
    assign rem_sh   = {high_q, low_q[WIDTH-1]};
    assign rem_ge   = rem_sh >= {1'b0, opb_q};
    assign rem_diff = rem_sh - {1'b0, opb_q};

    assign prod     = {high_q, low_q};
    assign div_zero = (opb_q == '0);
    // With a zero divisor every trial subtract succeeds, so the remainder holds |a| and this
    // sign fix-up restores the original a as required.
    assign rem_signed = sa_q ? -high_q : high_q;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        opb_d    = opb_q;
        high_d   = high_q;
        low_d    = low_q;
        cnt_d    = cnt_q;
        hi_out_d = hi_out_q;
        lo_out_d = lo_out_q;
        done_d   = 1'b0;
        hi_w_d   = 1'b0;
        lo_w_d   = 1'b0;
        rd_w_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_d    = op;
                    sa_d    = a_neg;
                    sb_d    = b_neg;
                    low_d   = a_neg ? -a : a;
                    opb_d   = b_neg ? -b : b;
                    high_d  = '0;
                    cnt_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (op_q[1]) begin
                    if (rem_ge) begin
                        high_d = rem_diff[WIDTH-1:0];
                        low_d  = {low_q[WIDTH-2:0], 1'b1};
                    end else begin
                        high_d = rem_sh[WIDTH-1:0];
                        low_d  = {low_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    high_d = mul_sum[WIDTH:1];
                    low_d  = {mul_sum[0], low_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                case (op_q)
                    OpMul: begin
                        {hi_out_d, lo_out_d} = (sa_q ^ sb_q) ? -prod : prod;
                        rd_w_d = 1'b1;
                    end
                    OpMultu: begin
                        {hi_out_d, lo_out_d} = prod;
                        hi_w_d = 1'b1;
                        lo_w_d = 1'b1;
                    end
                    OpDiv: begin
                        hi_out_d = rem_signed;
                        if (div_zero) begin
                            lo_out_d = '1;
                        end else begin
                            lo_out_d = (sa_q ^ sb_q) ? -low_q : low_q;
                        end
                        hi_w_d = 1'b1;
                        lo_w_d = 1'b1;
                    end
                    OpDivu: begin
                        hi_out_d = high_q;
                        lo_out_d = div_zero ? '1 : low_q;
                        hi_w_d   = 1'b1;
                        lo_w_d   = 1'b1;
                    end
                    default: ;
                endcase
                done_d  = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Abort wins over everything: results keep their old values, no strobes.
        if (flush) begin
            state_d  = StIdle;
            hi_out_d = hi_out_q;
            lo_out_d = lo_out_q;
            done_d   = 1'b0;
            hi_w_d   = 1'b0;
            lo_w_d   = 1'b0;
            rd_w_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            opb_q    <= '0;
            high_q   <= '0;
            low_q    <= '0;
            cnt_q    <= '0;
            hi_out_q <= '0;
            lo_out_q <= '0;
            done_q   <= 1'b0;
            hi_w_q   <= 1'b0;
            lo_w_q   <= 1'b0;
            rd_w_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            opb_q    <= opb_d;
            high_q   <= high_d;
            low_q    <= low_d;
            cnt_q    <= cnt_d;
            hi_out_q <= hi_out_d;
            lo_out_q <= lo_out_d;
            done_q   <= done_d;
            hi_w_q   <= hi_w_d;
            lo_w_q   <= lo_w_d;
            rd_w_q   <= rd_w_d;
        end
    end

    assign stall  = ((state_q == StIdle) && start) || (state_q == StCalc) || (state_q == StFix);
    assign busy   = (state_q != StIdle);
    // A flush arriving in the DONE cycle still suppresses the already-registered strobes.
    assign done   = done_q & ~flush;
    assign hi_w   = hi_w_q & ~flush;
    assign lo_w   = lo_w_q & ~flush;
    assign rd_w   = rd_w_q & ~flush;
    assign hi_out = hi_out_q;
    assign lo_out = lo_out_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        hi_w;
    logic        lo_w;
    logic        rd_w;

    int total;
    int bad;

    muldiv_sequencer #(
        .WIDTH(32),
        .CNT_W(6)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .hi_out (hi_out),
        .lo_out (lo_out),
        .hi_w   (hi_w),
        .lo_w   (lo_w),
        .rd_w   (rd_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference results {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        logic signed [63:0] sx, sy, sq, sr;
        logic [63:0] r;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        case (o)
            2'b00: r = sx * sy;
            2'b01: r = {32'd0, x} * {32'd0, y};
            2'b10: begin
                if (y == 0) r = {x, 32'hFFFF_FFFF};
                else begin
                    sq = sx / sy;
                    sr = sx % sy;
                    r  = {sr[31:0], sq[31:0]};
                end
            end
            default: begin
                if (y == 0) r = {x, 32'hFFFF_FFFF};
                else r = {x % y, x / y};
            end
        endcase
        return r;
    endfunction

    task automatic issue(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = aa;
        b     = bb;
    endtask

    // Issue one operation and check latency, stall profile, results and strobes.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] aa,
                          input logic [31:0] bb, input logic [31:0] eh, input logic [31:0] el);
        int lat;
        bit st_ok;
        st_ok = 1'b1;
        issue(o, aa, bb);
        #1;
        if (stall !== 1'b1) st_ok = 1'b0;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 100) begin
            if (stall !== 1'b1) st_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'd34);
        chk({tag, " stall before done"}, 64'(st_ok), 64'd1);
        chk({tag, " stall in done"}, 64'(stall), 64'd0);
        chk({tag, " busy in done"}, 64'(busy), 64'd1);
        chk({tag, " hi_out"}, 64'(hi_out), 64'(eh));
        chk({tag, " lo_out"}, 64'(lo_out), 64'(el));
        chk({tag, " rd_w"}, 64'(rd_w), 64'(o == 2'b00));
        chk({tag, " hi_w"}, 64'(hi_w), 64'(o != 2'b00));
        chk({tag, " lo_w"}, 64'(lo_w), 64'(o != 2'b00));
        @(negedge clk);
        chk({tag, " done cleared"}, 64'(done), 64'd0);
        chk({tag, " idle after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] exp;
        logic [31:0] ra, rb;
        logic [1:0]  ro;
        int cnt;
        int strobes;

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        flush = 1'b0;

        vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[4] = '{2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
        vecs[5] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[6] = '{2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
        vecs[7] = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[8] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset stall", 64'(stall), 64'd0);
        chk("reset hi_out", 64'(hi_out), 64'd0);
        chk("reset lo_out", 64'(lo_out), 64'd0);
        chk("reset strobes", 64'({hi_w, lo_w, rd_w}), 64'd0);
        rst = 1'b0;

        // Directed vectors
        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi,
                   vecs[i].lo);
        end

        // Randomized operations against the reference model
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = '0;
            else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            exp = model(ro, ra, rb);
            run_op($sformatf("rand%0d", i), ro, ra, rb, exp[63:32], exp[31:0]);
        end

        // start during an operation is ignored: DIVU 100/7 with a MULTU 5*5 at cycle 10
        issue(2'b11, 32'd100, 32'd7);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        a     = 32'd5;
        b     = 32'd5;
        @(negedge clk);
        start = 1'b0;
        cnt   = 11;
        while (done !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("ignored start latency", 64'(cnt), 64'd34);
        chk("ignored start hi_out", 64'(hi_out), 64'd2);
        chk("ignored start lo_out", 64'(lo_out), 64'd14);
        chk("ignored start hi_w", 64'(hi_w), 64'd1);
        @(negedge clk);

        // flush at cycle 5 of a DIVU
        issue(2'b11, 32'd1000, 32'd3);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush cycle strobes", 64'({done, hi_w, lo_w, rd_w}), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        chk("flush idle next", 64'(busy), 64'd0);
        strobes = 0;
        for (int k = 0; k < 40; k++) begin
            if (done || hi_w || lo_w || rd_w || busy) strobes++;
            @(negedge clk);
        end
        chk("flush no activity after", 64'(strobes), 64'd0);
        chk("flush hi_out kept", 64'(hi_out), 64'd2);
        chk("flush lo_out kept", 64'(lo_out), 64'd14);

        // flush in the DONE cycle suppresses the strobes
        issue(2'b01, 32'd3, 32'd4);
        @(negedge clk);
        start = 1'b0;
        cnt   = 1;
        while (done !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("done flush latency", 64'(cnt), 64'd34);
        flush = 1'b1;
        #1;
        chk("done flush strobes", 64'({done, hi_w, lo_w, rd_w}), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        chk("done flush idle", 64'(busy), 64'd0);

        // rst pulse at cycle 20 of a MULTU
        issue(2'b01, 32'd9, 32'd9);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        chk("pre-reset busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid reset busy", 64'(busy), 64'd0);
        chk("mid reset outputs", {hi_out, lo_out}, 64'd0);
        chk("mid reset strobes", 64'({done, hi_w, lo_w, rd_w, stall}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("after reset", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
